// File: rtl/fp_mult_pkg.sv
// ---------------------------------------------------------------------------
// fp_mult_pkg
//
// Shared definitions for the FP multiplier mantissa datapath:
//   - state_t     : control-state encoding of the sequential mantissa multiplier
//   - FP_MANT_W   : double-precision mantissa width, hidden bit included
//   - calc_iter() : number of shift-add iterations for a width / radix pair
// ---------------------------------------------------------------------------
package fp_mult_pkg;

  // Double-precision mantissa: 52 stored fraction bits plus the hidden bit.
  localparam int FP_MANT_W = 53;

  // Encodings are fixed so that the control FSM and debug views agree on them.
  // The fourth encoding (2'b11) is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Ceiling division: the number of iterations needed to retire every
  // multiplier bit when bpc bits are consumed per cycle.
  function automatic int calc_iter(input int width, input int bpc);
    return (width + bpc - 1) / bpc;
  endfunction

endpackage

// File: rtl/mant_mult_step.sv
// ---------------------------------------------------------------------------
// mant_mult_step
//
// One combinational shift-add iteration of the unsigned mantissa multiplier.
// The partial product (multiplier digit * multiplicand) is added to the
// running accumulator, then the sum is shifted right by BITS_PER_CYCLE.
// The bits that fall off the bottom of the accumulator are returned so the
// caller can shift them into the top of its multiplier register.
//
// Ports:
//   acc_i         in  WIDTH+BITS_PER_CYCLE  running accumulator
//   mplier_bits_i in  BITS_PER_CYCLE        low multiplier digit for this step
//   mcand_i       in  WIDTH                 multiplicand
//   acc_o         out WIDTH+BITS_PER_CYCLE  accumulator after add and shift
//   shift_out_o   out BITS_PER_CYCLE        low sum bits shifted out
// ---------------------------------------------------------------------------
module mant_mult_step
  import fp_mult_pkg::*;
#(
  parameter  int WIDTH          = FP_MANT_W,
  parameter  int BITS_PER_CYCLE = 1,
  localparam int AW             = WIDTH + BITS_PER_CYCLE
) (
  input  logic [AW-1:0]             acc_i,
  input  logic [BITS_PER_CYCLE-1:0] mplier_bits_i,
  input  logic [WIDTH-1:0]          mcand_i,
  output logic [AW-1:0]             acc_o,
  output logic [BITS_PER_CYCLE-1:0] shift_out_o
);

  logic [AW-1:0] pp;
  logic [AW-1:0] sum;

  // The accumulator always stays below mcand after the shift, so
  // acc + digit*mcand < 2^BITS_PER_CYCLE * mcand and never overflows AW bits.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    pp = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mplier_bits_i[k]) begin
        pp = pp + (AW'(mcand_i) << k);
      end
    end
    sum         = acc_i + pp;
    acc_o       = sum >> BITS_PER_CYCLE;
    shift_out_o = sum[BITS_PER_CYCLE-1:0];
  end

endmodule

// File: rtl/mant_mult_seq.sv
// ---------------------------------------------------------------------------
// mant_mult_seq
//
// Iterative unsigned mantissa multiplier for the FP multiplier datapath.
// Responds to the control FSM's start/done handshake; latency is fixed at
// ITER+1 edges after the start edge regardless of operand values, so the
// controller can predict the done cycle exactly.
//
// Ports:
//   clk      in   1        clock, rising edge
//   rst      in   1        synchronous active-high reset, priority over start
//   start    in   1        request pulse; a and b valid in the same cycle
//   a        in   WIDTH    multiplicand, unsigned
//   b        in   WIDTH    multiplier, unsigned
//   product  out  2*WIDTH  full product a*b; stable while done=1
//   done     out  1        result valid; held until next accepted start or rst
//   busy     out  1        high while iterating
// ---------------------------------------------------------------------------
module mant_mult_seq
  import fp_mult_pkg::*;
#(
  parameter int WIDTH          = FP_MANT_W,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               done,
  output logic               busy
);

  localparam int ITER = calc_iter(WIDTH, BITS_PER_CYCLE);
  // Multiplier register is padded up to a whole number of digits; for an odd
  // WIDTH with two bits per cycle, b is zero-extended by one bit at capture.
  localparam int MW   = ITER * BITS_PER_CYCLE;
  localparam int AW   = WIDTH + BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);
  localparam int PW   = 2 * WIDTH;

  state_t                    state_q;
  logic [CW-1:0]             cnt_q;
  logic [WIDTH-1:0]          mcand_q;
  logic [MW-1:0]             mplier_q;
  logic [AW-1:0]             acc_q;
  logic [PW-1:0]             product_q;
  logic                      done_q;
  logic                      busy_q;

  logic [AW-1:0]             acc_d;
  logic [BITS_PER_CYCLE-1:0] shift_out;
  logic [MW-1:0]             mplier_d;
  logic [PW-1:0]             product_d;

  mant_mult_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc_i         (acc_q),
    .mplier_bits_i (mplier_q[BITS_PER_CYCLE-1:0]),
    .mcand_i       (mcand_q),
    .acc_o         (acc_d),
    .shift_out_o   (shift_out)
  );

  // {acc, mplier} behaves as one double-length shift register: the bits
  // shifted out of the accumulator refill the top of the multiplier.
  assign mplier_d  = {shift_out, mplier_q[MW-1:BITS_PER_CYCLE]};
  // After the last step the concatenation holds a*b exactly; only the low
  // 2*WIDTH bits can be non-zero.
  assign product_d = PW'({acc_d, mplier_d});

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the operand registers are plain flops, not a memory, so clearing
      // them on reset is cheap and keeps the block fully deterministic.
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        // A start from DONE is accepted exactly like one from IDLE, which
        // allows back-to-back operations without an idle bubble.
        IDLE, DONE: begin
          if (start) begin
            mcand_q  <= a;
            mplier_q <= MW'(b);
            acc_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end

        // start is deliberately not looked at here: an in-flight operation
        // always completes with its captured operands.
        RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(ITER - 1)) begin
            product_q <= product_d;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= DONE;
          end
        end

        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign product = product_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mant_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_mant_mult_seq
//
// Three instances share one clock and reset:
//   dut 1 : WIDTH=53, BITS_PER_CYCLE=1  (ITER=53, done 54 edges after start)
//   dut 2 : WIDTH=53, BITS_PER_CYCLE=2  (ITER=27, done 28 edges after start)
//   dut 3 : WIDTH=8,  BITS_PER_CYCLE=1  (ITER=8,  done 9 edges after start)
// Expected products are plain a*b in 128-bit arithmetic.
// ---------------------------------------------------------------------------
module tb_mant_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         s1, s2, s3;
  logic [52:0]  a1, b1, a2, b2;
  logic [7:0]   a3, b3;
  logic [105:0] p1, p2;
  logic [15:0]  p3;
  logic         d1, d2, d3;
  logic         bz1, bz2, bz3;

  mant_mult_seq #(.WIDTH(53), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1),
    .product(p1), .done(d1), .busy(bz1)
  );

  mant_mult_seq #(.WIDTH(53), .BITS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(s2), .a(a2), .b(b2),
    .product(p2), .done(d2), .busy(bz2)
  );

  mant_mult_seq #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut3 (
    .clk(clk), .rst(rst), .start(s3), .a(a3), .b(b3),
    .product(p3), .done(d3), .busy(bz3)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Last product each instance delivered; product must hold it until the
  // next RUN->DONE transition or reset.
  logic [127:0] last_p [1:3];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int iter_of(input int w);
    case (w)
      1:       return 53;
      2:       return 27;
      default: return 8;
    endcase
  endfunction

  function automatic int width_of(input int w);
    return (w == 3) ? 8 : 53;
  endfunction

  function automatic logic [127:0] ref_prod(input int width, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] mask;
    logic [127:0] am;
    logic [127:0] bm;
    mask = (128'd1 << width) - 128'd1;
    am   = {64'd0, a} & mask;
    bm   = {64'd0, b} & mask;
    return am * bm;
  endfunction

  function automatic logic [127:0] get_p(input int w);
    case (w)
      1:       return 128'(p1);
      2:       return 128'(p2);
      default: return 128'(p3);
    endcase
  endfunction

  function automatic logic [127:0] get_d(input int w);
    case (w)
      1:       return 128'(d1);
      2:       return 128'(d2);
      default: return 128'(d3);
    endcase
  endfunction

  function automatic logic [127:0] get_b(input int w);
    case (w)
      1:       return 128'(bz1);
      2:       return 128'(bz2);
      default: return 128'(bz3);
    endcase
  endfunction

  task automatic set_op(input int w, input logic st, input logic [63:0] a, input logic [63:0] b);
    case (w)
      1:       begin s1 = st; a1 = a[52:0]; b1 = b[52:0]; end
      2:       begin s2 = st; a2 = a[52:0]; b2 = b[52:0]; end
      default: begin s3 = st; a3 = a[7:0];  b3 = b[7:0];  end
    endcase
  endtask

  task automatic set_start(input int w, input logic st);
    case (w)
      1:       s1 = st;
      2:       s2 = st;
      default: s3 = st;
    endcase
  endtask

  // Issue one operation and follow it edge by edge. inject_at > 0 pulses a
  // second start (a=3, b=5) during RUN; rst_at > 0 resets during RUN instead
  // of letting the operation finish.
  task automatic op(input int w, input logic [63:0] a, input logic [63:0] b,
                    input string tag, input int inject_at, input int rst_at);
    int           it;
    logic [127:0] exp;
    it  = iter_of(w);
    exp = ref_prod(width_of(w), a, b);
    set_op(w, 1'b1, a, b);
    tick();
    for (int c = 1; c <= it; c++) begin
      if (c == rst_at) begin
        rst = 1'b1;
        set_op(w, 1'b1, 64'd3, 64'd5);
        tick();
        rst = 1'b0;
        set_start(w, 1'b0);
        check({tag, " rst done"}, get_d(w), '0);
        check({tag, " rst busy"}, get_b(w), '0);
        check({tag, " rst product"}, get_p(w), '0);
        tick();
        check({tag, " rst start dropped"}, get_b(w), '0);
        for (int k = 1; k <= 3; k++) last_p[k] = '0;
        return;
      end
      if (c == inject_at) set_op(w, 1'b1, 64'd3, 64'd5);
      else                set_start(w, 1'b0);
      check({tag, " busy"}, get_b(w), 128'd1);
      check({tag, " done low"}, get_d(w), '0);
      if (c == 1 || c == it) check({tag, " product held"}, get_p(w), last_p[w]);
      tick();
    end
    set_start(w, 1'b0);
    check({tag, " done"}, get_d(w), 128'd1);
    check({tag, " busy low"}, get_b(w), '0);
    check({tag, " product"}, get_p(w), exp);
    last_p[w] = exp;
  endtask

  localparam logic [63:0] M53 = (64'd1 << 53) - 64'd1;

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic [63:0] edge_v [0:5];

    rst = 1'b1;
    s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
    a1 = '0; b1 = '0; a2 = '0; b2 = '0; a3 = '0; b3 = '0;
    for (int k = 1; k <= 3; k++) last_p[k] = '0;
    repeat (3) tick();
    for (int w = 1; w <= 3; w++) begin
      check("reset product", get_p(w), '0);
      check("reset done", get_d(w), '0);
      check("reset busy", get_b(w), '0);
    end
    rst = 1'b0;
    tick();

    // 1.0 x 1.0 mantissas, then all-ones, then a zero multiplicand.
    op(1, 64'd1 << 52, 64'd1 << 52, "one_x_one", 0, 0);
    op(1, M53, M53, "max_x_max", 0, 0);
    op(1, 64'd0, M53, "zero_x_max", 0, 0);

    // A start during RUN is ignored; then done and product hold while idle.
    op(1, 64'h0012_3456_789A_BCDE, 64'h001F_EDCB_A987_6543, "ignore_start", 10, 0);
    for (int k = 0; k < 20; k++) begin
      check("hold done", get_d(1), 128'd1);
      check("hold product", get_p(1), last_p[1]);
      tick();
    end

    // Back-to-back start accepted directly from DONE.
    op(1, 64'd3, 64'd5, "from_done", 0, 0);

    // Reset mid-RUN, then a fresh operation completes normally.
    op(1, M53, 64'd12345, "abort", 0, 20);
    op(1, 64'd7, 64'd9, "after_rst", 0, 0);

    // Two bits per cycle, odd width: edge values first, then random pairs.
    edge_v[0] = 64'd1 << 52;
    edge_v[1] = M53;
    edge_v[2] = 64'd0;
    edge_v[3] = 64'd1;
    edge_v[4] = 64'h0015_5555_5555_5555;
    edge_v[5] = 64'h000A_AAAA_AAAA_AAAA;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        op(2, edge_v[i], edge_v[j], "bpc2_edge", 0, 0);
      end
    end
    for (int i = 0; i < 600; i++) begin
      ra = {$urandom, $urandom} & M53;
      rb = {$urandom, $urandom} & M53;
      op(2, ra, rb, "bpc2_rand", 0, 0);
    end

    // Narrow instance.
    op(3, 64'd255, 64'd255, "w8_max", 0, 0);
    for (int i = 0; i < 20; i++) begin
      ra = 64'($urandom_range(0, 255));
      rb = 64'($urandom_range(0, 255));
      op(3, ra, rb, "w8_rand", 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
